// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Constants and FSM state encoding shared by the main memory
//                controller, its storage array and the cache above it.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_WIDTH    = 10;
    localparam int DATA_WIDTH    = 32;
    localparam int MEM_WORD_BITS = 2;
    localparam int DEPTH         = 2 ** (ADDR_WIDTH - MEM_WORD_BITS);

    // Every transfer walks IDLE -> BUSY -> ACK -> GAP -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } mem_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/main_memory_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_ctrl_if
//  Description : Cache <-> main memory miss-transfer bus.
//                master : cache side (drives request, direction, address, data)
//                slave  : memory side (returns read data and the Done pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
interface main_memory_ctrl_if #(
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
);
    logic                  mem_request;
    logic                  read_write_mem;
    logic [ADDR_WIDTH-1:0] address_mem;
    logic [DATA_WIDTH-1:0] write_data_mem;
    logic [DATA_WIDTH-1:0] read_data_mem;
    logic                  Done;

    modport master (
        output mem_request, read_write_mem, address_mem, write_data_mem,
        input  read_data_mem, Done
    );

    modport slave (
        input  mem_request, read_write_mem, address_mem, write_data_mem,
        output read_data_mem, Done
    );
endinterface : main_memory_ctrl_if
`default_nettype wire

// File: rtl/main_memory_array.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_array
//  Description : DEPTH x DATA_WIDTH word store with synchronous write and
//                registered read. Reset loads mem[k] = k and clears the read
//                register so contents are deterministic after every reset.
//  Ports       : clk, reset (async, active-high)
//                i_we / i_re  write / read strobe for the addressed word
//                i_idx        word index
//                i_wdata      write data
//                o_rdata      registered read data (holds when i_re is low)
//  Revision    : 1.0 - initial release
// ============================================================================
module main_memory_array #(
    parameter int DEPTH      = mem_pkg::DEPTH,
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
) (
    input  wire                          clk,
    input  wire                          reset,
    input  wire                          i_we,
    input  wire                          i_re,
    input  wire  [$clog2(DEPTH)-1:0]     i_idx,
    input  wire  [DATA_WIDTH-1:0]        i_wdata,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= DATA_WIDTH'(k);
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule : main_memory_array
`default_nettype wire

// File: rtl/main_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_ctrl
//  Description : Fixed-latency word memory serving the cache's single-word
//                write-backs and line fills. A request seen in IDLE is
//                captured, the access is performed LATENCY cycles later and
//                acknowledged by a one-cycle Done pulse; ACK and GAP then give
//                the cache time to advance its address before the next capture.
//  Ports       : clk    single clock
//                reset  asynchronous, active-high
//                bus    main_memory_ctrl_if.slave (request, rw, address,
//                       write data in; read data, Done out)
//  Revision    : 1.0 - initial release
// ============================================================================
module main_memory_ctrl #(
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int DEPTH      = mem_pkg::DEPTH,
    parameter int LATENCY    = 4
) (
    input  wire                      clk,
    input  wire                      reset,
    main_memory_ctrl_if.slave        bus
);
    import mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("main_memory_ctrl: LATENCY must be >= 1");
        end
    endgenerate

    mem_state_t             r_state;
    mem_state_t             w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic                   r_rw;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_done;

    logic                   w_capture;
    logic                   w_access;
    logic                   w_we;
    logic                   w_re;

    // Byte-offset bits carry no information for a word store.
    logic                   w_unused_addr;
    assign w_unused_addr = ^bus.address_mem[MEM_WORD_BITS-1:0];

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.mem_request) w_state_next = ST_BUSY;
            ST_BUSY: if (r_count == '0)   w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_GAP;
            ST_GAP:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_capture = 1'b0;
        w_access  = 1'b0;
        case (r_state)
            ST_IDLE: w_capture = bus.mem_request;
            ST_BUSY: w_access  = (r_count == '0);
            default: ;
        endcase
        w_we = w_access &  r_rw;
        w_re = w_access & ~r_rw;
    end

    // ---------------- capture registers, latency counter, Done ----------------
    // Everything the access needs is frozen at capture, so the cache may move
    // its address/data lines while the transfer is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_rw    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_count <= CNT_W'(LATENCY - 1);
                r_rw    <= bus.read_write_mem;
                r_idx   <= bus.address_mem[MEM_WORD_BITS +: IDX_W];
                r_wdata <= bus.write_data_mem;
            end else if (r_state == ST_BUSY && r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
            // High exactly for the ACK cycle.
            r_done <= w_access;
        end
    end

    main_memory_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (bus.read_data_mem)
    );

    assign bus.Done = r_done;

endmodule : main_memory_ctrl
`default_nettype wire

// File: tb/tb_main_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_memory_ctrl
//  Description : Directed self-checking bench for main_memory_ctrl with a
//                word-level memory model and an expected-read-data queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_ctrl;

    localparam int LATENCY = 4;
    localparam int PERIOD  = LATENCY + 3;

    logic clk;
    logic reset;
    int   cyc;
    int   n_asserts;
    int   n_fails;
    int   prev_done_cyc;

    logic [31:0] model [256];
    logic [31:0] rd_hold;
    logic [31:0] exp_q [$];

    main_memory_ctrl_if bus ();

    main_memory_ctrl #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .DEPTH      (256),
        .LATENCY    (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 256; k++) model[k] = 32'(k);
        rd_hold = '0;
        exp_q.delete();
    endtask

    // One transfer: capture on the first posedge after the inputs are driven,
    // Done expected exactly LATENCY edges later and nowhere else.
    task automatic transfer(input logic rw, input logic [9:0] addr, input logic [31:0] wdata,
                            input bit drop, input bit keep_req, input bit chk_period);
        logic [31:0] idx_word;
        idx_word = 32'(addr[9:2]);
        if (rw) begin
            exp_q.push_back(rd_hold);
        end else begin
            rd_hold = model[idx_word];
            exp_q.push_back(rd_hold);
        end
        @(negedge clk);
        bus.mem_request    = 1'b1;
        bus.read_write_mem = rw;
        bus.address_mem    = addr;
        bus.write_data_mem = wdata;
        @(posedge clk);
        #1;
        // Disturb the inputs; the captured copies must be used.
        @(negedge clk);
        bus.address_mem    = addr ^ 10'h2A8;
        bus.write_data_mem = ~wdata;
        bus.read_write_mem = ~rw;
        if (drop) bus.mem_request = 1'b0;
        for (int i = 1; i <= LATENCY + 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("done_c%0d", i), 32'(bus.Done), 32'(i == LATENCY));
            if (i == LATENCY) begin
                check("rdata", bus.read_data_mem, exp_q.pop_front());
                if (chk_period) check("period", 32'(cyc - prev_done_cyc), 32'(PERIOD));
                prev_done_cyc = cyc;
            end
            if (i == 1) bus.read_write_mem = rw;
        end
        if (rw) model[idx_word] = wdata;
        if (!keep_req) bus.mem_request = 1'b0;
    endtask

    initial begin
        n_asserts     = 0;
        n_fails       = 0;
        prev_done_cyc = 0;
        reset              = 1'b1;
        bus.mem_request    = 1'b0;
        bus.read_write_mem = 1'b0;
        bus.address_mem    = '0;
        bus.write_data_mem = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus.Done), 32'h0);
        check("rst_rdata", bus.read_data_mem, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic read: word 4 holds its reset value.
        transfer(1'b0, 10'h010, 32'h0, 1'b0, 1'b0, 1'b0);

        // Write to the top word, then read it back.
        transfer(1'b1, 10'h3FC, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        transfer(1'b0, 10'h3FC, 32'h0, 1'b0, 1'b0, 1'b0);
        check("top_word", bus.read_data_mem, 32'hDEADBEEF);

        // Four-word burst with mem_request held high throughout.
        transfer(1'b0, 10'h120, 32'h0, 1'b0, 1'b1, 1'b0);
        transfer(1'b0, 10'h124, 32'h0, 1'b0, 1'b1, 1'b1);
        transfer(1'b0, 10'h128, 32'h0, 1'b0, 1'b1, 1'b1);
        transfer(1'b0, 10'h12C, 32'h0, 1'b0, 1'b0, 1'b1);
        check("burst_last", bus.read_data_mem, 32'h0000004B);

        // Byte offset ignored.
        transfer(1'b0, 10'h013, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a write: no Done, write lost.
        @(negedge clk);
        bus.mem_request    = 1'b1;
        bus.read_write_mem = 1'b1;
        bus.address_mem    = 10'h040;
        bus.write_data_mem = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        bus.mem_request = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("mid_rst_rdata", bus.read_data_mem, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_nodone", 32'(bus.Done), 32'h0);
        end
        transfer(1'b0, 10'h040, 32'h0, 1'b0, 1'b0, 1'b0);
        check("lost_write", bus.read_data_mem, 32'h00000010);

        // Request dropped right after capture: one Done, then quiet.
        transfer(1'b0, 10'h008, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_nodone", 32'(bus.Done), 32'h0);
        end
        check("idle_hold", bus.read_data_mem, 32'h00000002);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule : tb_main_memory_ctrl
`default_nettype wire

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Word-organised backing store directly downstream of the 4-block direct-mapped cache.
- Serves the cache's single-word miss transfers: write-backs and line fills, four words per line.
- Each accepted transfer completes after a fixed latency and is acknowledged with a one-cycle Done pulse.
- The cache advances address_mem on the rising edge of Done.

Parameters:
- ADDR_WIDTH, 10: byte-address width, matching the cache address.
- DATA_WIDTH, 32: word width.
- DEPTH, 256: number of words, equal to 2^(ADDR_WIDTH-2).
- LATENCY, 4: clock cycles from request capture to Done. Must be >= 1; elaboration error otherwise.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_request  input  1  held high by the cache while a miss transfer sequence is in progress.
- read_write_mem  input  1  1 = write, 0 = read; sampled at capture.
- address_mem  input  ADDR_WIDTH  byte address; bits [1:0] ignored; word index = address_mem[9:2].
- write_data_mem  input  DATA_WIDTH  write data; sampled at capture.
- read_data_mem  output  DATA_WIDTH  registered read data.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous and active-high:
  - Done=0, read_data_mem=0, state=IDLE, counter=0.
  - Array initialised to mem[k]=k for k=0..DEPTH-1, so contents are deterministic for verification.
  - Any in-flight transfer is abandoned; a pending write is lost.
- FSM states: IDLE, BUSY, ACK, GAP.
- IDLE: on the edge where mem_request=1:
  - capture rw, word index and wdata;
  - counter <= LATENCY-1;
  - go to BUSY.
- BUSY:
  - Captured values are used from here on; later input changes are ignored.
  - If counter==0: perform the access, set Done<=1, go to ACK.
  - Otherwise decrement the counter.
- Access in BUSY:
  - Read: read_data_mem <= mem[idx].
  - Write: mem[idx] <= wdata; read_data_mem holds its previous value.
- ACK: Done<=0, go to GAP.
  - The cache updates address_mem and write_data_mem off the Done rising edge, so the inputs are stable before GAP ends.
- GAP: go to IDLE. No capture happens in ACK or GAP.
- Timing:
  - If capture is at edge N, Done is high from edge N+LATENCY to edge N+LATENCY+1.
  - Back-to-back transfer period is LATENCY+3 cycles: 7 cycles at LATENCY=4.
- Done never stays high for more than one cycle.
- Exactly one Done is produced per capture.
- mem_request dropped after capture: the transfer still completes and Done still pulses. The FSM then idles.
- mem_request low in IDLE: no activity; outputs hold their values.
- read_data_mem changes only in the Done cycle of a read, or on reset.
- Address arithmetic: the word index is taken modulo DEPTH, so there is no out-of-range case. Address 0x3FC maps to word 255.
- Write then read of the same word in successive transfers returns the new data; there is no hazard because transfers are serialised.

Decomposition:
- Shared package mem_pkg:
  - FSM state encoding (IDLE, BUSY, ACK, GAP);
  - MEM_WORD_BITS = 2;
  - the constants ADDR_WIDTH, DATA_WIDTH and DEPTH, shared with the cache.
- Sub-module main_memory_array:
  - DEPTH x DATA_WIDTH storage;
  - synchronous write enable, registered read;
  - asynchronous reset initialisation to mem[k]=k.
- The FSM, latency counter and capture registers live in main_memory_ctrl.

Test Plan:
- Reset, then read 0x010 with LATENCY=4 -> Done pulses once, 4 cycles after capture; read_data_mem = 0x00000004.
- Write 0xDEADBEEF to 0x3FC, then read 0x3FC:
  - read_data_mem unchanged during the write's Done;
  - the read returns 0xDEADBEEF.
- Four-read burst from 0x120, address += 4 on each Done, mem_request held high -> data 0x48, 0x49, 0x4A, 0x4B; Done rising edges exactly 7 cycles apart.
- Read 0x013 -> returns 0x00000004, identical to 0x010 because the byte offset is ignored.
- Assert reset during BUSY of a write of 0x55 to 0x040:
  - Done never pulses;
  - a subsequent read of 0x040 returns 0x00000010.
- Drop mem_request one cycle after capture -> exactly one Done pulse, then no further activity for 20 cycles.
